// File: rtl/mdu_if.sv
// +----------------------------------------------------------------------------
// | mdu_if : issue/result bundle between the issue stage and the mdu
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/mdu.sv
// +----------------------------------------------------------------------------
// | mdu : iterative multiply/divide unit holding the architectural HI/LO pair
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mdu #(
   parameter int WIDTH = 32
) (
   input  wire logic clk,
   input  wire logic rst,
   mdu_if.slave      bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   logic [1:0]         state_q,   state_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic               is_div_q,  is_div_d;
   logic               neg_q,     neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               div0_q,    div0_d;
   logic [WIDTH-1:0]   opnd_q,    opnd_d;
   logic [2*WIDTH-1:0] acc_q,     acc_d;
   logic [WIDTH-1:0]   hi_q,      hi_d;
   logic [WIDTH-1:0]   lo_q,      lo_d;
   logic               done_q,    done_d;

   logic               is_arith;
   logic               is_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               last_iter;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Op 0..3 are the iterative ops; bit 1 picks divide, bit 0 clear means signed.
   assign is_arith  = ~bus.op[2];
   assign is_signed = ~bus.op[0];
   assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
   assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
   assign last_iter = (count_q == CNT_W'(WIDTH - 1));

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge   = (div_sh >= {1'b0, opnd_q});
   assign div_sub  = div_sh[WIDTH-1:0] - opnd_q;
   assign acc_step = is_div_q
                   ? {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
                   : {mul_sum, acc_q[WIDTH-1:1]};

   assign prod_fix = neg_q     ? (~acc_q + 1'b1) : acc_q;
   assign quo_fix  = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start && is_arith) state_d = S_CALC;
         S_CALC:  if (last_iter)             state_d = S_FIX;
         S_FIX:                              state_d = S_IDLE;
         default:                            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (is_arith) begin
                  is_div_d  = bus.op[1];
                  neg_d     = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  rem_neg_d = is_signed && bus.a[WIDTH-1];
                  div0_d    = (bus.b == '0);
                  opnd_d    = bus.op[1] ? b_mag : a_mag;
                  acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                  count_d   = '0;
               end else if (bus.op == OP_MTHI) begin
                  hi_d = bus.a;
               end else if (bus.op == OP_MTLO) begin
                  lo_d = bus.a;
               end
            end
         end
         S_CALC: begin
            acc_d   = acc_step;
            count_d = count_q + 1'b1;
         end
         S_FIX: begin
            done_d = 1'b1;
            if (is_div_q) begin
               // Divide by zero: remainder path already yields the dividend.
               hi_d = rem_fix;
               lo_d = div0_q ? '1 : quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: ;
      endcase
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// +----------------------------------------------------------------------------
// | tb_mdu : directed self-checking bench for the multiply/divide unit
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mdu;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   mdu_if #(.WIDTH(WIDTH)) bus ();

   mdu #(.WIDTH(WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for exactly the E0 cycle, then scramble the operands.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 3'd7;
      bus.a     = 32'hDEADBEEF;
      bus.b     = 32'h0BAD0BAD;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          cyc;
      logic        moved;
      logic [31:0] h0;
      logic [31:0] l0;
      cyc   = 0;
      moved = 1'b0;
      h0    = bus.hi;
      l0    = bus.lo;
      issue(o, x, y);
      while (bus.busy && cyc < 100) begin
         if (bus.hi !== h0 || bus.lo !== l0 || bus.done) moved = 1'b1;
         cyc++;
         @(posedge clk);
         #1;
      end
      check({tag, ".busy_cycles"}, 64'(cyc), 64'd33);
      check({tag, ".done"},        64'(bus.done), 64'd1);
      check({tag, ".hold"},        64'(moved), 64'd0);
      check({tag, ".hi"},          64'(bus.hi), 64'(exp_hi));
      check({tag, ".lo"},          64'(bus.lo), 64'(exp_lo));
   endtask

   initial begin
      int cyc;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", 64'(bus.busy), 64'd0);
      check("reset.done", 64'(bus.done), 64'd0);
      check("reset.hi",   64'(bus.hi),   64'd0);
      check("reset.lo",   64'(bus.lo),   64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single-cycle moves on consecutive edges.
      bus.start = 1'b1;
      bus.op    = 3'd4;
      bus.a     = 32'hAAAA5555;
      @(posedge clk);
      #1;
      check("mthi.hi",   64'(bus.hi),   64'hAAAA5555);
      check("mthi.lo",   64'(bus.lo),   64'd0);
      check("mthi.busy", 64'(bus.busy), 64'd0);
      bus.op = 3'd5;
      bus.a  = 32'h1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("mtlo.lo",   64'(bus.lo),   64'd1);
      check("mtlo.hi",   64'(bus.hi),   64'hAAAA5555);
      check("mtlo.done", 64'(bus.done), 64'd0);

      // Asynchronous reset in the middle of an operation.
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(posedge clk);
      #1;
      check("midop.busy_before", 64'(bus.busy), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("midop.busy", 64'(bus.busy), 64'd0);
      check("midop.done", 64'(bus.done), 64'd0);
      check("midop.hi",   64'(bus.hi),   64'd0);
      check("midop.lo",   64'(bus.lo),   64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      run("multu_3x5", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);
      run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      @(posedge clk);
      #1;
      check("multu_max.done_pulse", 64'(bus.done), 64'd0);
      run("mult_neg",  3'd0, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6);
      @(posedge clk);
      #1;
      run("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      // Issued in the done cycle of the previous divide.
      run("divu_b2b",  3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      run("divu_by0",  3'd3, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
      run("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      // A second request while busy must be dropped.
      issue(3'd1, 32'd2, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 3'd1;
      bus.a     = 32'd100;
      bus.b     = 32'd100;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 100) begin
         cyc++;
         @(posedge clk);
         #1;
      end
      check("ignore.done", 64'(bus.done), 64'd1);
      check("ignore.hi",   64'(bus.hi),   64'd0);
      check("ignore.lo",   64'(bus.lo),   64'd6);
      repeat (40) @(posedge clk);
      #1;
      check("ignore.idle", 64'(bus.busy), 64'd0);
      check("ignore.lo_after", 64'(bus.lo), 64'd6);

      // Reserved opcode has no effect.
      bus.start = 1'b1;
      bus.op    = 3'd6;
      bus.a     = 32'h55;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("nop.busy", 64'(bus.busy), 64'd0);
      check("nop.hi",   64'(bus.hi),   64'd0);
      check("nop.lo",   64'(bus.lo),   64'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
